// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: load handshake and digit-drive signals of display_scan_ctrl.
interface display_scan_ctrl_if #(parameter int NUM_DIGITS = 8);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    value_valid;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic                    value_ready;
    logic [3:0]              nibble;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   AN;
    logic                    frame_done;
    modport master (
        output value_in, value_valid, dp_in, blank_lz,
        input  value_ready, nibble, dp_out, AN, frame_done
    );
    modport slave (
        input  value_in, value_valid, dp_in, blank_lz,
        output value_ready, nibble, dp_out, AN, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed seven-segment scanner with tear-free double-buffered value load.
// DISPLAY_GHOST_BLANK_EN: hold all anodes off for the first 4 cycles of every digit slot.
module display_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 100000
) (
    input logic                clock,
    input logic                reset_n,
    display_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $fatal(1, "display_scan_ctrl: NUM_DIGITS must be 2..8");
    end
    if (TICK_DIV < 8) begin : g_bad_div
        $fatal(1, "display_scan_ctrl: TICK_DIV must be 8 or more");
    end

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic                  full_q, full_d;
    logic [NUM_DIGITS-1:0] an_sel_q, an_sel_d;
    logic [3:0]            nib_q, nib_d;
    logic                  dp_q, dp_d;
    logic                  tick, wrap, load;
    logic [NUM_DIGITS-1:0] blank, an_new;

    assign tick = cnt_q == CNT_MAX;
    assign wrap = tick && idx_q == IDX_MAX;
    assign load = bus.value_valid && !full_q;

    // Pending only moves to active on a wrap that began with full already set.
    always_comb begin
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = tick ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
        pend_val_d = load ? bus.value_in : pend_val_q;
        pend_dp_d  = load ? bus.dp_in : pend_dp_q;
        full_d     = load || (full_q && !wrap);
        act_val_d  = (wrap && full_q) ? pend_val_q : act_val_q;
        act_dp_d   = (wrap && full_q) ? pend_dp_q : act_dp_q;
    end

    // Slot outputs are built from the index and active value that take effect at this edge.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        blank    = '0;
        an_new   = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run  = zero_run && act_val_d[4*i +: 4] == 4'h0;
            blank[i]  = bus.blank_lz && zero_run && i > 0;
            an_new[i] = idx_d != IW'(i) || blank[i];
        end
        an_sel_d = tick ? an_new : an_sel_q;
        nib_d    = tick ? (blank[idx_d] ? 4'h0 : act_val_d[{idx_d, 2'b00} +: 4]) : nib_q;
        dp_d     = tick ? act_dp_d[idx_d] && !blank[idx_d] : dp_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            full_q     <= 1'b0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            an_sel_q   <= '1;
            nib_q      <= 4'h0;
            dp_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            full_q     <= full_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            an_sel_q   <= an_sel_d;
            nib_q      <= nib_d;
            dp_q       <= dp_d;
        end
    end

`ifdef DISPLAY_GHOST_BLANK_EN
    logic [NUM_DIGITS-1:0] an_q;
    always_ff @(posedge clock) begin
        an_q <= (!reset_n || cnt_d < CW'(4)) ? '1 : an_sel_d;
    end
    assign bus.AN = an_q;
`else
    assign bus.AN = an_sel_q;
`endif

    assign bus.value_ready = !full_q;
    assign bus.nibble      = nib_q;
    assign bus.dp_out      = dp_q;
    assign bus.frame_done  = wrap;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed checks of scan timing, buffered loads and blanking (TICK_DIV=8, 8 digits).
module tb_display_scan_ctrl;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    display_scan_ctrl_if #(.NUM_DIGITS(8)) bus ();

    display_scan_ctrl #(.NUM_DIGITS(8), .TICK_DIV(8)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        bus.value_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    // Advance to 1 time unit after the k-th rising edge since reset release.
    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clock);
            cyc++;
        end
        #1;
    endtask

    task automatic load(input logic [31:0] v, input logic [7:0] dp);
        bus.value_in = v;
        bus.dp_in = dp;
        bus.value_valid = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp8;
        do_reset();
        n_cmp++; if (bus.AN !== 8'hFF) begin n_bad++; $display("FAIL reset_an: got %h want ff", bus.AN); end
        n_cmp++; if (bus.value_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.value_ready); end
        n_cmp++; if (bus.nibble !== 4'h0) begin n_bad++; $display("FAIL reset_nibble: got %h want 0", bus.nibble); end
        n_cmp++; if (bus.dp_out !== 1'b0) begin n_bad++; $display("FAIL reset_dp: got %b want 0", bus.dp_out); end
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
        for (int c = 1; c < 8; c++) begin
            goto(c);
            n_cmp++; if (bus.AN !== 8'hFF) begin n_bad++; $display("FAIL first_tick_early c=%0d: got %h want ff", c, bus.AN); end
        end
`ifdef DISPLAY_GHOST_BLANK_EN
        exp8 = 8'hFF;
`else
        exp8 = 8'hFD;
`endif
        goto(8);
        n_cmp++; if (bus.AN !== exp8) begin n_bad++; $display("FAIL first_tick: got %h want %h", bus.AN, exp8); end
    endtask

    task automatic test_scan();
        logic [7:0] ea;
        logic [3:0] en;
        do_reset();
        bus.blank_lz = 1'b0;
        goto(1);
        load(32'h12345678, 8'h00);
        goto(2);
        bus.value_valid = 1'b0;
        n_cmp++; if (bus.value_ready !== 1'b0) begin n_bad++; $display("FAIL scan_ready_low: got %b want 0", bus.value_ready); end
        goto(62);
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL scan_fd_before: got %b want 0", bus.frame_done); end
        goto(63);
        n_cmp++; if (bus.frame_done !== 1'b1) begin n_bad++; $display("FAIL scan_fd_wrap: got %b want 1", bus.frame_done); end
        goto(64);
        n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL scan_fd_after: got %b want 0", bus.frame_done); end
        n_cmp++; if (bus.value_ready !== 1'b1) begin n_bad++; $display("FAIL scan_ready_rise: got %b want 1", bus.value_ready); end
        for (int k = 0; k < 8; k++) begin
            goto(64 + 8 * k + 4);
            ea = ~(8'h01 << k);
            en = 4'(8 - k);
            n_cmp++; if (bus.AN !== ea) begin n_bad++; $display("FAIL scan_an k=%0d: got %h want %h", k, bus.AN, ea); end
            n_cmp++; if (bus.nibble !== en) begin n_bad++; $display("FAIL scan_nib k=%0d: got %h want %h", k, bus.nibble, en); end
        end
        goto(127);
        n_cmp++; if (bus.frame_done !== 1'b1) begin n_bad++; $display("FAIL scan_fd_period: got %b want 1", bus.frame_done); end
    endtask

    task automatic test_tear_free();
        goto(130);
        load(32'hAAAAAAAA, 8'h00);
        goto(131);
        bus.value_valid = 1'b0;
        n_cmp++; if (bus.value_ready !== 1'b0) begin n_bad++; $display("FAIL tear_ready: got %b want 0", bus.value_ready); end
        goto(164);
        n_cmp++; if (bus.nibble !== 4'h4) begin n_bad++; $display("FAIL tear_old_value: got %h want 4", bus.nibble); end
        goto(191);
        n_cmp++; if (bus.value_ready !== 1'b0) begin n_bad++; $display("FAIL tear_ready_wrap: got %b want 0", bus.value_ready); end
        goto(192);
        n_cmp++; if (bus.value_ready !== 1'b1) begin n_bad++; $display("FAIL tear_ready_rise: got %b want 1", bus.value_ready); end
        goto(196);
        n_cmp++; if (bus.AN !== 8'hFE || bus.nibble !== 4'hA) begin n_bad++; $display("FAIL tear_new_d0: got %h/%h want fe/a", bus.AN, bus.nibble); end
        goto(204);
        n_cmp++; if (bus.AN !== 8'hFD || bus.nibble !== 4'hA) begin n_bad++; $display("FAIL tear_new_d1: got %h/%h want fd/a", bus.AN, bus.nibble); end
    endtask

    task automatic test_back_to_back();
        goto(205);
        load(32'h11111111, 8'h00);
        goto(206);
        bus.value_in = 32'h22222222;
        n_cmp++; if (bus.value_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_first_taken: got %b want 0", bus.value_ready); end
        goto(230);
        n_cmp++; if (bus.value_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got %b want 0", bus.value_ready); end
        goto(255);
        n_cmp++; if (bus.frame_done !== 1'b1) begin n_bad++; $display("FAIL b2b_wrap: got %b want 1", bus.frame_done); end
        goto(256);
        n_cmp++; if (bus.value_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_rise: got %b want 1", bus.value_ready); end
        goto(257);
        bus.value_valid = 1'b0;
        n_cmp++; if (bus.value_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_second_taken: got %b want 0", bus.value_ready); end
        goto(260);
        n_cmp++; if (bus.AN !== 8'hFE || bus.nibble !== 4'h1) begin n_bad++; $display("FAIL b2b_first_shown: got %h/%h want fe/1", bus.AN, bus.nibble); end
        goto(316);
        n_cmp++; if (bus.AN !== 8'h7F || bus.nibble !== 4'h1) begin n_bad++; $display("FAIL b2b_first_d7: got %h/%h want 7f/1", bus.AN, bus.nibble); end
        goto(324);
        n_cmp++; if (bus.AN !== 8'hFE || bus.nibble !== 4'h2) begin n_bad++; $display("FAIL b2b_second_shown: got %h/%h want fe/2", bus.AN, bus.nibble); end
    endtask

    task automatic test_wrap_load();
        goto(383);
        n_cmp++; if (bus.frame_done !== 1'b1 || bus.value_ready !== 1'b1) begin n_bad++; $display("FAIL wl_wrap_ready: got fd=%b rdy=%b want 1/1", bus.frame_done, bus.value_ready); end
        load(32'h33333333, 8'h00);
        goto(384);
        bus.value_valid = 1'b0;
        n_cmp++; if (bus.value_ready !== 1'b0) begin n_bad++; $display("FAIL wl_taken: got %b want 0", bus.value_ready); end
        goto(388);
        n_cmp++; if (bus.nibble !== 4'h2) begin n_bad++; $display("FAIL wl_no_early_xfer: got %h want 2", bus.nibble); end
        goto(447);
        n_cmp++; if (bus.value_ready !== 1'b0) begin n_bad++; $display("FAIL wl_held: got %b want 0", bus.value_ready); end
        goto(452);
        n_cmp++; if (bus.nibble !== 4'h3 || bus.value_ready !== 1'b1) begin n_bad++; $display("FAIL wl_xfer: got %h rdy=%b want 3 rdy=1", bus.nibble, bus.value_ready); end
    endtask

    task automatic test_leading_zero();
        logic [31:0] v;
        logic [7:0]  ea;
        logic [3:0]  en;
        logic        ed;
        v = 32'h00000305;
        goto(453);
        bus.blank_lz = 1'b1;
        load(v, 8'hFF);
        goto(454);
        bus.value_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            goto(512 + 8 * k + 4);
            ea = k < 3 ? ~(8'h01 << k) : 8'hFF;
            en = k < 3 ? v[4*k +: 4] : 4'h0;
            ed = k < 3;
            n_cmp++; if (bus.AN !== ea || bus.nibble !== en || bus.dp_out !== ed) begin
                n_bad++; $display("FAIL lz k=%0d: got an=%h nib=%h dp=%b want %h/%h/%b", k, bus.AN, bus.nibble, bus.dp_out, ea, en, ed);
            end
        end
        goto(573);
        load(32'h0, 8'h00);
        goto(574);
        bus.value_valid = 1'b0;
        goto(580);
        n_cmp++; if (bus.AN !== 8'hFE || bus.nibble !== 4'h0) begin n_bad++; $display("FAIL lz_zero_d0: got %h/%h want fe/0", bus.AN, bus.nibble); end
        goto(588);
        n_cmp++; if (bus.AN !== 8'hFF) begin n_bad++; $display("FAIL lz_zero_d1: got %h want ff", bus.AN); end
        goto(636);
        n_cmp++; if (bus.AN !== 8'hFF) begin n_bad++; $display("FAIL lz_zero_d7: got %h want ff", bus.AN); end
        goto(641);
        bus.blank_lz = 1'b0;
        goto(652);
        n_cmp++; if (bus.AN !== 8'hFD || bus.nibble !== 4'h0) begin n_bad++; $display("FAIL lz_live_off: got %h/%h want fd/0", bus.AN, bus.nibble); end
    endtask

    task automatic test_reset_discard();
        do_reset();
        goto(3);
        load(32'h99999999, 8'hFF);
        goto(4);
        bus.value_valid = 1'b0;
        n_cmp++; if (bus.value_ready !== 1'b0) begin n_bad++; $display("FAIL rd_loaded: got %b want 0", bus.value_ready); end
        goto(5);
        do_reset();
        n_cmp++; if (bus.value_ready !== 1'b1) begin n_bad++; $display("FAIL rd_ready: got %b want 1", bus.value_ready); end
        goto(63);
        n_cmp++; if (bus.frame_done !== 1'b1) begin n_bad++; $display("FAIL rd_wrap: got %b want 1", bus.frame_done); end
        goto(68);
        n_cmp++; if (bus.AN !== 8'hFE || bus.nibble !== 4'h0 || bus.dp_out !== 1'b0) begin
            n_bad++; $display("FAIL rd_discard: got %h/%h/%b want fe/0/0", bus.AN, bus.nibble, bus.dp_out);
        end
    endtask

    task automatic test_ghost();
        logic [7:0] ea;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            goto(8 + c);
`ifdef DISPLAY_GHOST_BLANK_EN
            ea = c < 4 ? 8'hFF : 8'hFD;
`else
            ea = 8'hFD;
`endif
            n_cmp++; if (bus.AN !== ea) begin n_bad++; $display("FAIL ghost c=%0d: got %h want %h", c, bus.AN, ea); end
        end
    endtask

    initial begin
        bus.value_in = '0;
        bus.value_valid = 1'b0;
        bus.dp_in = '0;
        bus.blank_lz = 1'b0;
        test_reset();
        test_scan();
        test_tear_free();
        test_back_to_back();
        test_wrap_load();
        test_leading_zero();
        test_reset_discard();
        test_ghost();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8: number of multiplexed digits, legal values 2..8.
REQ-002 The block SHALL have parameter TICK_DIV, default 100000: clock cycles per digit slot, legal values 8 and above.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock, rising edge active.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port value_in, input, 4*NUM_DIGITS bits: hex number to display; nibble i drives digit i, nibble 0 is the LSB digit.
REQ-006 The block SHALL have port value_valid, input, 1 bit: value_in and dp_in are offered for load.
REQ-007 The block SHALL have port dp_in, input, NUM_DIGITS bits: decimal-point enable per digit, captured together with value_in.
REQ-008 The block SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable, sampled live.
REQ-009 The block SHALL have port value_ready, output, 1 bit: the pending register is free.
REQ-010 The block SHALL have port nibble, output, 4 bits: 4-bit code for the seven-segment decoder.
REQ-011 The block SHALL have port dp_out, output, 1 bit: decimal point for the current digit, active-high.
REQ-012 The block SHALL have port AN, output, NUM_DIGITS bits: digit anodes, active-low, at most one bit low at a time.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame wrap.

Function
REQ-014 Prescaler: the prescaler SHALL count 0..TICK_DIV-1 and wrap; tick is asserted in the cycle where the count equals TICK_DIV-1.
REQ-015 Digit index: on tick, the digit index SHALL increment; from NUM_DIGITS-1 it SHALL wrap to 0.
REQ-016 Frame wrap: frame_done SHALL be high for exactly the one cycle in which the index wraps.
REQ-017 Output latency: AN, nibble and dp_out SHALL be registered and SHALL reflect the new index one cycle after the tick.
REQ-018 Two-stage buffer: the value path SHALL use a pending register (value, dp, full flag) and an active register (value, dp); outputs SHALL be sourced from active only.
REQ-019 Load handshake: a load SHALL occur on value_valid and value_ready both high; the pending register captures, full is set, and value_ready goes low the next cycle.
REQ-020 Tear-free transfer: if full is set at a frame wrap, pending SHALL be copied to active in that wrap cycle, full SHALL be cleared, and value_ready SHALL rise the next cycle.
REQ-021 Load on the wrap cycle: a load accepted in a wrap cycle SHALL NOT transfer in that same cycle; it SHALL wait for the next wrap.
REQ-022 Valid while not ready: value_valid asserted with value_ready low SHALL be ignored, with no stall or drop of the pending data.
REQ-023 Leading-zero blanking: when blank_lz=1, digit i>0 SHALL be blanked (AN bit high) if active nibbles i..NUM_DIGITS-1 are all zero.
REQ-024 Digit 0 SHALL never be blanked by leading-zero blanking.
REQ-025 Blanked slot: in a blanked slot, nibble SHALL be 0 and dp_out SHALL be 0, and the prescaler and index SHALL keep running.
REQ-026 Parameter checks: parameter legality SHALL be checked at elaboration; an illegal value is a fatal error.

Reset
REQ-027 With reset_n low at a clock edge, the block SHALL set: prescaler 0, index 0, AN all ones, nibble 0, dp_out 0, frame_done 0, value_ready 1, full 0, active value 0, active dp 0.
REQ-028 A reset asserted mid-slot or mid-handshake SHALL discard pending data, and no partial transfer to active SHALL occur.
REQ-029 The first tick after reset release SHALL occur TICK_DIV cycles later.

Configuration
REQ-030 Macro DISPLAY_GHOST_BLANK_EN SHALL select anti-ghosting behaviour at compile time.
REQ-031 With DISPLAY_GHOST_BLANK_EN defined, AN SHALL be held all ones for the first 4 cycles of every slot; nibble and dp_out SHALL update at slot start as normal.
REQ-032 Without DISPLAY_GHOST_BLANK_EN, AN SHALL assert for the full slot per REQ-017.

Verification (TICK_DIV=8, NUM_DIGITS=8)
REQ-033 Reset: reset_n=0 for 3 cycles, then 1 -> AN=8'hFF, value_ready=1, first AN change 8 cycles after release.
REQ-034 Scan: load 32'h12345678 after reset -> after the next wrap, AN walks FE,FD,...,7F each 8 cycles with nibble 8,7,...,1; frame_done pulses once per 64 cycles.
REQ-035 Tear-free: load 32'hAAAAAAAA mid-frame -> value_ready low until the wrap; active digits keep showing the old value until the wrap, then show A on all digits.
REQ-036 Back-pressure: assert value_valid continuously with two distinct values -> the second value is accepted only after value_ready rises post-wrap, and both values are displayed in order.
REQ-037 Leading zeros: blank_lz=1, value 32'h00000305 -> AN bits 7..3 never go low; digits 2,1,0 show 3,0,5; with value 0, only digit 0 lights, showing 0.
REQ-038 Ghost blank: with DISPLAY_GHOST_BLANK_EN defined -> AN=8'hFF for 4 cycles after each slot start; without it, no gap appears.
